// File: rtl/tx_mac_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tx_mac_arbiter
// Description : Two-port frame-locked round-robin AXI-Stream arbiter feeding
//               a single tx_mac, with per-port completed-frame counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_mac_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,

  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s0_axis_tkeep,
  input  logic                  s0_axis_tvalid,
  input  logic                  s0_axis_tlast,
  output logic                  s0_axis_trdy,

  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s1_axis_tkeep,
  input  logic                  s1_axis_tvalid,
  input  logic                  s1_axis_tlast,
  output logic                  s1_axis_trdy,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_trdy,

  output logic [1:0]            o_grant,
  output logic [CNT_WIDTH-1:0]  o_frame_cnt0,
  output logic [CNT_WIDTH-1:0]  o_frame_cnt1
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic                 rr_ptr;
  logic                 last_xfer;
  logic [1:0]           grant;
  logic [CNT_WIDTH-1:0] frame_cnt0;
  logic [CNT_WIDTH-1:0] frame_cnt1;

  assign last_xfer = m_axis_tvalid & m_axis_trdy & m_axis_tlast;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Leaving a grant only on a completed tlast beat makes the grant frame-locked
  // and forces an IDLE cycle between any two frames.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (s0_axis_tvalid && s1_axis_tvalid) begin
          state_nxt = rr_ptr ? GRANT1 : GRANT0;
        end else if (s0_axis_tvalid) begin
          state_nxt = GRANT0;
        end else if (s1_axis_tvalid) begin
          state_nxt = GRANT1;
        end else begin
          state_nxt = IDLE;
        end
      end
      GRANT0:  state_nxt = last_xfer ? IDLE : GRANT0;
      GRANT1:  state_nxt = last_xfer ? IDLE : GRANT1;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s0_axis_trdy  = 1'b0;
    s1_axis_trdy  = 1'b0;
    case (state)
      GRANT0: begin
        m_axis_tdata  = s0_axis_tdata;
        m_axis_tkeep  = s0_axis_tkeep;
        m_axis_tvalid = s0_axis_tvalid;
        m_axis_tlast  = s0_axis_tlast;
        s0_axis_trdy  = m_axis_trdy;
      end
      GRANT1: begin
        m_axis_tdata  = s1_axis_tdata;
        m_axis_tkeep  = s1_axis_tkeep;
        m_axis_tvalid = s1_axis_tvalid;
        m_axis_tlast  = s1_axis_tlast;
        s1_axis_trdy  = m_axis_trdy;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rr_ptr     <= 1'b0;
      frame_cnt0 <= '0;
      frame_cnt1 <= '0;
    end else if (last_xfer) begin
      if (state == GRANT0) begin
        rr_ptr     <= 1'b1;
        frame_cnt0 <= frame_cnt0 + CNT_ONE;
      end else begin
        rr_ptr     <= 1'b0;
        frame_cnt1 <= frame_cnt1 + CNT_ONE;
      end
    end
  end

  // Decoded from the next state so the registered grant lines up with state.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      grant <= 2'b00;
    end else begin
      case (state_nxt)
        GRANT0:  grant <= 2'b01;
        GRANT1:  grant <= 2'b10;
        default: grant <= 2'b00;
      endcase
    end
  end

  assign o_grant      = grant;
  assign o_frame_cnt0 = frame_cnt0;
  assign o_frame_cnt1 = frame_cnt1;

endmodule
`default_nettype wire
